// File: rtl/game_flow_ctrl_if.sv
// Draw-request bus between the object drawers and game_flow_ctrl.
// master: drawers (drive requests, see select); slave: controller.
interface game_flow_ctrl_if #(
    parameter int NUM_HAZARDS = 4
);
    logic [NUM_HAZARDS-1:0] hazard_draw_req;
    logic                   gate_a_draw_req;
    logic                   gate_b_draw_req;
    logic                   frog_draw_req;
    logic                   endbank_draw_req;
    logic [7:0]             select_mux;

    modport master (
        output hazard_draw_req,
        output gate_a_draw_req,
        output gate_b_draw_req,
        output frog_draw_req,
        output endbank_draw_req,
        input  select_mux
    );

    modport slave (
        input  hazard_draw_req,
        input  gate_a_draw_req,
        input  gate_b_draw_req,
        input  frog_draw_req,
        input  endbank_draw_req,
        output select_mux
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Frog game flow controller: draw arbitration, collisions, PLAY/WIN/LOSE/BUZ/GAMEOVER.
// Ports: clk, resetN (async low), draw (bus slave), start; outputs win, lose,
// game_over, gate_take, gate_sel, enable_sound, sound_freq, level, lives, log_enable.
// Macro GAME_LIVES_EN enables the lives counter and GAMEOVER; otherwise play is endless.
module game_flow_ctrl #(
    parameter int         NUM_HAZARDS    = 4,
    parameter int         NUM_LOGS       = 15,
    parameter int         LOGS_PER_LEVEL = 5,
    parameter int         LIVES          = 3,
    parameter int         MAX_LEVEL      = 8,
    parameter int         BUZ_CYCLES     = 50000000,
    parameter logic [9:0] WIN_FREQ       = 10'd500,
    parameter logic [9:0] LOSE_FREQ      = 10'd950
) (
    input  logic                clk,
    input  logic                resetN,
    game_flow_ctrl_if.slave     draw,
    input  logic                start,
    output logic                win,
    output logic                lose,
    output logic                game_over,
    output logic                gate_take,
    output logic                gate_sel,
    output logic                enable_sound,
    output logic [9:0]          sound_freq,
    output logic [7:0]          level,
    output logic [3:0]          lives,
    output logic [NUM_LOGS-1:0] log_enable
);
    typedef enum logic [2:0] {
        PLAY, WIN, LOSE, BUZ, GAMEOVER
    } state_t;

    localparam int CW = $clog2(BUZ_CYCLES + 1);
    localparam logic [CW-1:0] BUZ_LOAD = CW'(BUZ_CYCLES - 1);
    localparam logic [7:0] MAXL = 8'(MAX_LEVEL);

    state_t state, state_nxt;
    logic [CW-1:0] buz_cnt;
    logic [7:0] sel;
    logic [7:0] level_q, level_nxt;
    logic [NUM_LOGS-1:0] log_nxt;
    int log_cnt;
    logic in_play, hz_any, hit_lose, hit_win;
    logic contact, contact_q;
    logic out_of_lives, restart;

    // Later assignments win, so hazard 0 ends up with top priority.
    always_comb begin
        sel = '0;
        if (draw.endbank_draw_req) sel = 8'(NUM_HAZARDS + 4);
        if (draw.frog_draw_req)    sel = 8'(NUM_HAZARDS + 3);
        if (draw.gate_b_draw_req)  sel = 8'(NUM_HAZARDS + 2);
        if (draw.gate_a_draw_req)  sel = 8'(NUM_HAZARDS + 1);
        for (int i = NUM_HAZARDS - 1; i >= 0; i--)
            if (draw.hazard_draw_req[i]) sel = 8'(i + 1);
    end
    assign draw.select_mux = sel;

    assign in_play  = (state == PLAY);
    assign hz_any   = |draw.hazard_draw_req;
    assign hit_lose = in_play & draw.frog_draw_req & hz_any;
    assign hit_win  = in_play & draw.frog_draw_req
                    & draw.endbank_draw_req & ~hz_any;
    assign contact  = in_play & draw.frog_draw_req & ~hz_any
                    & (draw.gate_a_draw_req | draw.gate_b_draw_req);

`ifdef GAME_LIVES_EN
    logic [3:0] lives_q;
    assign lives        = lives_q;
    assign game_over    = (state == GAMEOVER);
    assign out_of_lives = (lives_q == 4'd0);
    assign restart      = (state == GAMEOVER) & start;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            lives_q <= 4'(LIVES);
        else if (restart)
            lives_q <= 4'(LIVES);
        else if (state == LOSE)
            lives_q <= lives_q - 4'd1;
    end
`else
    logic unused_start;
    assign unused_start = start;
    assign lives        = 4'(LIVES);
    assign game_over    = 1'b0;
    assign out_of_lives = 1'b0;
    assign restart      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            PLAY: begin
                if (hit_lose)     state_nxt = LOSE;
                else if (hit_win) state_nxt = WIN;
            end
            WIN, LOSE: state_nxt = BUZ;
            BUZ: begin
                if (buz_cnt == '0)
                    state_nxt = out_of_lives ? GAMEOVER : PLAY;
            end
            GAMEOVER: begin
                if (restart) state_nxt = PLAY;
            end
            default: state_nxt = PLAY;
        endcase
    end

    always_comb begin
        level_nxt = level_q;
        if (state == WIN && level_q < MAXL)
            level_nxt = level_q + 8'd1;
        if (state == LOSE && level_q > 8'd1)
            level_nxt = level_q - 8'd1;
        if (restart)
            level_nxt = 8'd1;
        // Counts past NUM_LOGS simply leave every bit set.
        log_cnt = (int'(level_nxt) - 1) * LOGS_PER_LEVEL;
        for (int i = 0; i < NUM_LOGS; i++)
            log_nxt[i] = (i < log_cnt);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= PLAY;
            buz_cnt    <= '0;
            level_q    <= 8'd1;
            log_enable <= '0;
            sound_freq <= '0;
            contact_q  <= 1'b0;
            gate_take  <= 1'b0;
            gate_sel   <= 1'b0;
        end else begin
            state      <= state_nxt;
            level_q    <= level_nxt;
            log_enable <= log_nxt;
            if (state == WIN || state == LOSE)
                buz_cnt <= BUZ_LOAD;
            else if (state == BUZ && buz_cnt != '0)
                buz_cnt <= buz_cnt - 1'b1;
            if (hit_lose)
                sound_freq <= LOSE_FREQ;
            else if (hit_win)
                sound_freq <= WIN_FREQ;
            contact_q <= contact;
            gate_take <= contact & ~contact_q;
            if (contact & ~contact_q)
                gate_sel <= draw.gate_a_draw_req;
        end
    end

    assign level        = level_q;
    assign win          = (state == WIN);
    assign lose         = (state == LOSE);
    assign enable_sound = (state == BUZ);
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-state controller for the frog VGA game; the next generation of the single-log game FSM. Arbitrates per-pixel draw requests from N hazard layers, two gates, the frog and the end bank into one mux select, detects collisions, and runs a PLAY/WIN/LOSE/BUZ/GAMEOVER flow. Tracks level and lives, and drives the log-enable mask and sound request. Sits between the object drawers and the RGB mux, and feeds the sound and score blocks.

## Interface
- NUM_HAZARDS, 4: hazard draw layers; lose on frog contact.
- NUM_LOGS, 15: width of log_enable.
- LOGS_PER_LEVEL, 5: logs added per level.
- LIVES, 3: lives at reset/start (1..15).
- MAX_LEVEL, 8: level saturation value (>=1, <=255).
- BUZ_CYCLES, 50000000: sound duration in clocks (>=1).
- WIN_FREQ, 500; LOSE_FREQ, 950: 10-bit sound codes.
- clk  in  1  system clock; the block uses this one clock only.
- resetN  in  1  reset, asynchronous, active-low.
- hazard_draw_req  in  NUM_HAZARDS  bit 0 = highest priority.
- gate_a_draw_req, gate_b_draw_req  in  1 each  gate pixels.
- frog_draw_req, endbank_draw_req  in  1 each.
- start  in  1  new-game pulse (used in GAMEOVER only).
- select_mux  out  8  0 bg, 1..NUM_HAZARDS hazard i-1, NUM_HAZARDS+1 gate A, +2 gate B, +3 frog, +4 endbank.
- win, lose, game_over, gate_take, gate_sel, enable_sound  out  1 each.
- sound_freq  out  10; level  out  8; lives  out  4; log_enable  out  NUM_LOGS.

## Operation
- select_mux is combinational, evaluated in every state. Priority order: hazards (lowest index first), then gate A, gate B, frog, endbank, background.
- States: PLAY, WIN, LOSE, BUZ, GAMEOVER. Reset state is PLAY.
- PLAY only: frog & any hazard sets next state LOSE. Otherwise, frog & endbank sets next state WIN. Hazard contact beats endbank contact in the same cycle.
- Gates, PLAY only: contact = frog & the highest-priority drawn gate, with no hazard drawn.
  - gate_take pulses for one cycle on the rising edge of contact, registered.
  - gate_sel = 1 for gate A contact (target B), 0 for gate B contact, registered. It holds its value until the next pulse.
- WIN, one cycle:
  - win = 1, sound_freq <= WIN_FREQ.
  - level <= min(level+1, MAX_LEVEL).
  - Next state BUZ.
- LOSE, one cycle:
  - lose = 1, sound_freq <= LOSE_FREQ.
  - level <= max(level-1, 1); lives <= lives-1.
  - Next state BUZ.
- log_enable is registered and updated with level. It holds the low min((level-1)*LOGS_PER_LEVEL, NUM_LOGS) bits set, all other bits 0.
- BUZ:
  - Counter loads BUZ_CYCLES-1 on entry; enable_sound = 1 for exactly BUZ_CYCLES cycles.
  - Exits to GAMEOVER if lives == 0, else to PLAY.
- GAMEOVER:
  - game_over = 1; collisions are ignored.
  - start: lives <= LIVES, level <= 1, log_enable <= 0, next state PLAY.
- start is ignored in every state other than GAMEOVER.

## Timing
- Reset values: state PLAY, level 1, lives LIVES, log_enable 0, sound_freq 0. win, lose, game_over, gate_take, gate_sel, enable_sound are all 0.
- Collision at cycle t: win or lose is high at t+1; enable_sound is high over t+2..t+1+BUZ_CYCLES; PLAY (or GAMEOVER) at t+2+BUZ_CYCLES.
- level, lives and log_enable update at the edge that leaves WIN/LOSE, i.e. they are valid from t+2.
- sound_freq is latched on entry to WIN/LOSE and held until the next WIN/LOSE.
- Contact during WIN/LOSE/BUZ is ignored; no events are queued.
- An asynchronous reset mid-BUZ aborts immediately to reset values.
- Level arithmetic saturates; no wrap at MAX_LEVEL or at 1.

## Configuration
- GAME_LIVES_EN defined: the lives counter and the GAMEOVER state exist, as described above.
- GAME_LIVES_EN undefined:
  - lives is tied to the constant LIVES and game_over is tied to 0.
  - BUZ always returns to PLAY and start is ignored.
  - Play is endless; level still moves up and down.

## Test plan
- Reset with NUM_HAZARDS=4, BUZ_CYCLES=5, defines on -> level=1, lives=3, log_enable=0, select_mux=0 with no requests.
- Hazard 2 + frog + endbank in one cycle in PLAY -> select_mux=3. Next cycle lose=1; then enable_sound for 5 cycles; level stays 1; lives=2; sound_freq=950.
- Three endbank wins -> level=4, log_enable=15'h7FFF (saturated), win pulses once per event. Contact held during BUZ causes no extra events.
- Three losses from LIVES=3 -> game_over=1 after the third BUZ. Collisions are ignored there; start -> PLAY, lives=3, level=1.
- Frog on gate A held for 10 cycles -> gate_take is a single 1-cycle pulse, gate_sel=1. Gate A + hazard 0 drawn together -> no pulse, select_mux=1.
- Same stimulus with GAME_LIVES_EN undefined, 4 losses -> game_over never asserts, lives=3 throughout, state returns to PLAY each time.
